// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin, packet-locked arbiter that lets several message sources share
// the single push port of the UART TX FIFO. A source is granted for a whole
// packet (up to its 'last' byte), so bytes from different sources never
// interleave. A watchdog evicts an owner that stops making progress, and an
// owner that drops its request mid-packet is treated as an abort.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  input  logic                 tx_full,
  output logic                 tx_push,
  output logic [7:0]           tx_push_data,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 timeout_err
);

  localparam int                 OW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0]   WDOG_LAST      = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]   WDOG_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] GRANT_ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0]      LAST_OWNER_RST = OW'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        last_owner_q, last_owner_d;
  logic [CNT_W-1:0]     wdog_q, wdog_d;
  logic                 busy_q, busy_d;
  logic                 pkt_done_q, pkt_done_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 own_req_s;
  logic                 own_valid_s;
  logic                 own_last_s;
  logic [7:0]           own_data_s;
  logic                 ready_ok_s;
  logic                 hs_s;

  logic                 pick_found_s;
  logic [OW-1:0]        pick_idx_s;
  logic [OW-1:0]        cand_idx_s;
  int                   cand_s;

  // Select the current owner's request, valid, last and data lanes (grant is one-hot or zero).
  always_comb begin
    own_req_s   = 1'b0;
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_data_s  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_req_s   = own_req_s   | (grant_q[i] & req[i]);
      own_valid_s = own_valid_s | (grant_q[i] & req_valid[i]);
      own_last_s  = own_last_s  | (grant_q[i] & req_last[i]);
      own_data_s  = own_data_s  | (req_data[8*i +: 8] & {8{grant_q[i]}});
    end
  end

  // The FIFO sees full and push in the same cycle, so ready is a pure function of tx_full.
  assign ready_ok_s   = (state_q == ST_XFER) & own_req_s & ~tx_full;
  assign hs_s         = ready_ok_s & own_valid_s;
  assign req_ready    = grant_q & {NUM_REQ{ready_ok_s}};
  assign tx_push      = hs_s;
  assign tx_push_data = own_data_s;

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign pkt_done    = pkt_done_q;
  assign timeout_err = timeout_err_q;

  // Rotating search: first requester after the previous owner, wrapping around.
  always_comb begin
    pick_found_s = 1'b0;
    pick_idx_s   = {OW{1'b0}};
    cand_s       = 0;
    cand_idx_s   = {OW{1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s     = (int'(last_owner_q) + k) % NUM_REQ;
      cand_idx_s = OW'(cand_s);
      if (!pick_found_s && req[cand_idx_s]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = cand_idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Next-state logic: grant on request, release on last byte, abort or watchdog expiry.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    last_owner_d  = last_owner_q;
    wdog_d        = wdog_q;
    pkt_done_d    = 1'b0;
    timeout_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wdog_d = {CNT_W{1'b0}};
        if (pick_found_s) begin
          state_d = ST_XFER;
          grant_d = GRANT_ONE << pick_idx_s;
          owner_d = pick_idx_s;
        end else begin
          state_d = ST_IDLE;
          grant_d = {NUM_REQ{1'b0}};
        end
      end
      ST_XFER: begin
        if (!own_req_s) begin
          // Owner withdrew its request before the last byte: abort wins over valid.
          state_d       = ST_IDLE;
          grant_d       = {NUM_REQ{1'b0}};
          last_owner_d  = owner_q;
          wdog_d        = {CNT_W{1'b0}};
          timeout_err_d = 1'b1;
        end else if (hs_s) begin
          // A transferred byte always restarts the watchdog, even on its final count.
          wdog_d = {CNT_W{1'b0}};
          if (own_last_s) begin
            state_d      = ST_IDLE;
            grant_d      = {NUM_REQ{1'b0}};
            last_owner_d = owner_q;
            pkt_done_d   = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end else if (wdog_q == WDOG_LAST) begin
          state_d       = ST_IDLE;
          grant_d       = {NUM_REQ{1'b0}};
          last_owner_d  = owner_q;
          wdog_d        = {CNT_W{1'b0}};
          timeout_err_d = 1'b1;
        end else begin
          // FIFO-full stalls count as idle cycles too.
          wdog_d = wdog_q + WDOG_ONE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        grant_d      = {NUM_REQ{1'b0}};
        owner_d      = {OW{1'b0}};
        last_owner_d = LAST_OWNER_RST;
        wdog_d       = {CNT_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_XFER);
  end

  // State and registered outputs; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= {NUM_REQ{1'b0}};
      owner_q       <= {OW{1'b0}};
      last_owner_q  <= LAST_OWNER_RST;
      wdog_q        <= {CNT_W{1'b0}};
      busy_q        <= 1'b0;
      pkt_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      last_owner_q  <= last_owner_d;
      wdog_q        <= wdog_d;
      busy_q        <= busy_d;
      pkt_done_q    <= pkt_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Randomised sources drive the arbiter; a cycle-level behavioural model of the
// arbitration rules (owner index, rotating priority, idle counter) predicts
// every output each cycle. Directed scenarios add end-of-scenario totals.
module tb_uart_tx_arbiter;
  localparam int N  = 3;
  localparam int T  = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tx_full, tx_push, busy, pkt_done, timeout_err;
  logic [7:0]     tx_push_data;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_valid(req_valid),
    .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .grant(grant), .tx_full(tx_full), .tx_push(tx_push),
    .tx_push_data(tx_push_data), .busy(busy), .pkt_done(pkt_done),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: owner index (-1 = none), previous owner, idle cycles
  int m_owner, m_last, m_wait;
  bit m_done, m_terr;

  // source agents
  int         pkt_left[N], extra_pkts[N], pkt_len[N], sent[N], abort_at[N], p_valid[N];
  logic [7:0] src_byte[N];
  int         p_start, p_abort, p_full, force_full;

  // scenario statistics, taken from DUT outputs
  int           cyc, push_cnt, full_push_cnt, terr_cnt, done_cnt, terr_cyc;
  int           push_by_src[N];
  logic [N-1:0] prev_grant;
  logic [N-1:0] grant_log[$];
  int           grant_cyc[$];

  task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_wait  = 0;
    m_done  = 1'b0;
    m_terr  = 1'b0;
  endtask

  task automatic agents_clear();
    for (int i = 0; i < N; i++) begin
      pkt_left[i] = 0; extra_pkts[i] = 0; pkt_len[i] = 2; sent[i] = 0;
      abort_at[i] = -1; p_valid[i] = 100; src_byte[i] = 8'($urandom);
    end
    p_start = 0; p_abort = 0; p_full = 0; force_full = 0;
    req = '0; req_valid = '0; req_last = '0; req_data = '0; tx_full = 1'b0;
  endtask

  task automatic stats_clear();
    push_cnt = 0; full_push_cnt = 0; terr_cnt = 0; done_cnt = 0; terr_cyc = -1;
    for (int i = 0; i < N; i++) push_by_src[i] = 0;
    prev_grant = '0;
    grant_log.delete();
    grant_cyc.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    agents_clear();
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_grant", grant, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_pkt_done", pkt_done, 0);
    check_value("rst_timeout_err", timeout_err, 0);
    check_value("rst_req_ready", req_ready, 0);
    check_value("rst_tx_push", tx_push, 0);
    reset_n = 1'b1;
    model_reset();
    stats_clear();
  endtask

  task automatic drive_inputs();
    bit dropped;
    for (int i = 0; i < N; i++) begin
      dropped = 1'b0;
      if (pkt_left[i] == 0 && extra_pkts[i] == 0 && $urandom_range(0, 999) < p_start) begin
        pkt_left[i] = $urandom_range(1, 5);
        sent[i]     = 0;
      end
      if (pkt_left[i] > 0 && (sent[i] == abort_at[i] || $urandom_range(0, 999) < p_abort)) begin
        pkt_left[i] = 0;
        dropped     = 1'b1;
      end
      req[i]             = (pkt_left[i] > 0);
      req_valid[i]       = (pkt_left[i] > 0 || dropped) && ($urandom_range(0, 99) < p_valid[i]);
      req_last[i]        = (pkt_left[i] == 1);
      req_data[8*i +: 8] = src_byte[i];
    end
    if (force_full > 0) begin
      tx_full = 1'b1;
      force_full--;
    end else begin
      tx_full = ($urandom_range(0, 99) < p_full);
    end
  endtask

  // One clock: apply inputs, check all outputs at the falling edge, advance model and agents.
  task automatic cycle();
    logic [N-1:0] e_grant, e_ready;
    logic         e_push;
    logic [7:0]   e_data;
    int           hs_src, evicted, c;
    bit           found;
    drive_inputs();
    @(negedge clk);
    e_grant = '0; e_ready = '0; e_push = 1'b0; e_data = 8'h00;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_ready[m_owner] = req[m_owner] && !tx_full;
      e_push           = e_ready[m_owner] && req_valid[m_owner];
      e_data           = src_byte[m_owner];
    end
    check_value("grant", grant, e_grant);
    check_value("busy", busy, (m_owner >= 0));
    check_value("req_ready", req_ready, e_ready);
    check_value("tx_push", tx_push, e_push);
    check_value("pkt_done", pkt_done, m_done);
    check_value("timeout_err", timeout_err, m_terr);
    if (e_push) check_value("tx_push_data", tx_push_data, e_data);

    if (tx_push) begin
      push_cnt++;
      for (int k = 0; k < N; k++) if (grant[k]) push_by_src[k]++;
      if (tx_full) full_push_cnt++;
    end
    if (timeout_err) begin
      terr_cnt++;
      if (terr_cyc < 0) terr_cyc = cyc;
    end
    if (pkt_done) done_cnt++;
    if (grant != '0 && prev_grant == '0) begin
      grant_log.push_back(grant);
      grant_cyc.push_back(cyc);
    end
    prev_grant = grant;

    hs_src = -1; evicted = -1; m_done = 1'b0; m_terr = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req[c]) begin
          found = 1'b1; m_owner = c; m_wait = 0;
        end
      end
    end else if (!req[m_owner]) begin
      m_terr = 1'b1; m_last = m_owner; m_owner = -1;
    end else if (e_push) begin
      hs_src = m_owner; m_wait = 0;
      if (req_last[m_owner]) begin
        m_done = 1'b1; m_last = m_owner; m_owner = -1;
      end
    end else if (m_wait == T - 1) begin
      m_terr = 1'b1; evicted = m_owner; m_last = m_owner; m_owner = -1;
    end else begin
      m_wait++;
    end

    if (hs_src >= 0) begin
      pkt_left[hs_src]--;
      sent[hs_src]++;
      src_byte[hs_src] = 8'($urandom);
      if (pkt_left[hs_src] == 0 && extra_pkts[hs_src] > 0) begin
        extra_pkts[hs_src]--;
        pkt_left[hs_src] = pkt_len[hs_src];
        sent[hs_src]     = 0;
      end
    end
    if (evicted >= 0) pkt_left[evicted] = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc = 0;
    reset_n = 1'b0;
    agents_clear();
    stats_clear();
    #12;

    // single 4-byte packet from source 0
    do_reset();
    pkt_left[0] = 4;
    repeat (8) cycle();
    check_value("t1_pushes", push_cnt, 4);
    check_value("t1_done", done_cnt, 1);
    check_value("t1_first_grant", grant_cyc.size() > 0 ? grant_cyc[0] - grant_cyc[0] + 1 : 0, 1);

    // all three request, 2 bytes each, source 0 has a second packet
    do_reset();
    for (int i = 0; i < N; i++) pkt_left[i] = 2;
    extra_pkts[0] = 1;
    repeat (24) cycle();
    check_value("t2_grants", grant_log.size(), 4);
    if (grant_log.size() == 4)
      check_value("t2_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 12'b001_010_100_001);
    check_value("t2_pushes", push_cnt, 8);
    check_value("t2_done", done_cnt, 4);

    // 5-cycle FIFO-full stall in the middle of a packet
    do_reset();
    pkt_left[1] = 4;
    repeat (3) cycle();
    force_full = 5;
    repeat (12) cycle();
    check_value("t3_pushes", push_cnt, 4);
    check_value("t3_push_while_full", full_push_cnt, 0);
    check_value("t3_done", done_cnt, 1);

    // owner never asserts valid: watchdog eviction, then the waiting source
    do_reset();
    pkt_left[2] = 3;
    p_valid[2]  = 0;
    cycle();
    pkt_left[0] = 2;
    repeat (16) cycle();
    check_value("t4_timeouts", terr_cnt, 1);
    check_value("t4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check_value("t4_first_owner", grant_log[0], 3'b100);
      check_value("t4_next_owner", grant_log[1], 3'b001);
      check_value("t4_wdog_cycles", terr_cyc - grant_cyc[0], T);
    end
    check_value("t4_src2_pushes", push_by_src[2], 0);
    check_value("t4_src0_pushes", push_by_src[0], 2);

    // owner drops req after 2 of 5 bytes, valid still high when it drops
    do_reset();
    pkt_left[0] = 5;
    abort_at[0] = 2;
    pkt_left[1] = 2;
    repeat (12) cycle();
    check_value("t5_src0_pushes", push_by_src[0], 2);
    check_value("t5_timeouts", terr_cnt, 1);
    check_value("t5_done", done_cnt, 1);
    if (grant_log.size() == 2) check_value("t5_next_owner", grant_log[1], 3'b010);
    else check_value("t5_grants", grant_log.size(), 2);

    // asynchronous reset in the middle of a packet
    do_reset();
    pkt_left[1] = 5;
    repeat (3) cycle();
    #2;
    reset_n = 1'b0;
    #1;
    check_value("t6_async_grant", grant, 0);
    check_value("t6_async_busy", busy, 0);
    check_value("t6_async_push", tx_push, 0);
    check_value("t6_async_ready", req_ready, 0);
    do_reset();
    pkt_left[0] = 2;
    pkt_left[2] = 2;
    repeat (10) cycle();
    if (grant_log.size() > 0) check_value("t6_first_owner", grant_log[0], 3'b001);
    else check_value("t6_grants", grant_log.size(), 2);
    check_value("t6_pushes", push_cnt, 4);

    // long randomised run against the model
    do_reset();
    p_start = 80; p_abort = 3; p_full = 20;
    p_valid[0] = 80; p_valid[1] = 60; p_valid[2] = 30;
    repeat (3000) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
